// File: rtl/llc_cmd_scheduler.sv
// Trace-command scheduler: buffers trace commands in a small FIFO and dispatches
// them one at a time to the LLC, handling clear/print housekeeping ops locally.
module llc_cmd_scheduler #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int DEPTH    = 4,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  output logic                llc_req_valid,
  input  logic                llc_req_ready,
  output logic [2:0]          llc_req_op,
  output logic [TAG_W-1:0]    llc_req_tag,
  output logic [INDEX_W-1:0]  llc_req_index,
  output logic [OFFSET_W-1:0] llc_req_offset,
  input  logic                llc_done,
  output logic                llc_clear,
  output logic                llc_print,
  output logic                busy,
  output logic [15:0]         cmd_count,
  output logic [15:0]         err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CLEAR_WAIT} state_t;

  state_t              state_q;
  logic [3:0]          op_mem   [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];
  logic [PW:0]         wr_q, rd_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                req_valid_q, clear_q, print_q;
  logic [15:0]         cmd_cnt_q, err_cnt_q;

  logic                empty, full, push, pop;
  logic [3:0]          head_op;
  logic [ADDR_W-1:0]   head_addr;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign push      = cmd_valid && !full;
  // Holding off while print is high keeps back-to-back prints as distinct pulses.
  assign pop       = (state_q == IDLE) && !empty && !print_q;
  assign head_op   = op_mem[rd_q[PW-1:0]];
  assign head_addr = addr_mem[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_q[PW-1:0]]   <= cmd_op;
      addr_mem[wr_q[PW-1:0]] <= cmd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      req_valid_q <= 1'b0;
      clear_q     <= 1'b0;
      print_q     <= 1'b0;
      cmd_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      clear_q <= 1'b0;
      print_q <= 1'b0;
      if (push) wr_q <= wr_q + PTR_ONE;
      case (state_q)
        IDLE: begin
          if (pop) begin
            rd_q   <= rd_q + PTR_ONE;
            op_q   <= head_op[2:0];
            addr_q <= head_addr;
            if (head_op <= 4'd6) begin
              state_q <= ISSUE;
            end else if (head_op == 4'd8) begin
              state_q <= CLEAR_WAIT;
              clear_q <= 1'b1;
            end else if (head_op == 4'd9) begin
              print_q <= 1'b1;
              if (cmd_cnt_q != 16'hFFFF) cmd_cnt_q <= cmd_cnt_q + 16'd1;
            end else begin
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
          end
        end
        // First ISSUE cycle raises valid; request then holds until accepted.
        ISSUE: begin
          if (!req_valid_q) begin
            req_valid_q <= 1'b1;
          end else if (llc_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT_DONE;
          end
        end
        WAIT_DONE, CLEAR_WAIT: begin
          if (llc_done) begin
            state_q <= IDLE;
            if (cmd_cnt_q != 16'hFFFF) cmd_cnt_q <= cmd_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = !full;
  assign llc_req_valid  = req_valid_q;
  assign llc_req_op     = op_q;
  assign llc_req_tag    = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
  assign llc_req_index  = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign llc_req_offset = addr_q[OFFSET_W-1:0];
  assign llc_clear      = clear_q;
  assign llc_print      = print_q;
  assign busy           = (state_q != IDLE) || !empty || clear_q || print_q;
  assign cmd_count      = cmd_cnt_q;
  assign err_count      = err_cnt_q;
endmodule
